// File: rtl/skid_pipe_pkg.sv
// Shared types and helpers for skid_pipeline and its stages.
package skid_pipe_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_t;

  function automatic int unsigned cnt_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/skid_pipeline_stage.sv
// One two-entry skid stage: main/skid registers, registered valid and ready.
// Optional SKID_PIPE_FLUSH_EN adds a synchronous clear input.
module skid_stage
  import skid_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SKID_PIPE_FLUSH_EN
  input  logic                  i_flush,
`endif
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  skid_state_t           r_state;
  skid_state_t           w_state_d;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_clr;

`ifdef SKID_PIPE_FLUSH_EN
  assign w_clr = i_flush;
`else
  assign w_clr = 1'b0;
`endif

  assign w_push = i_valid & r_ready & ~w_clr;
  assign w_pop  = r_valid & i_ready & ~w_clr;

  always_comb begin
    w_state_d = r_state;
    if (w_clr) begin
      w_state_d = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_push) w_state_d = ST_BUSY;
        ST_BUSY: begin
          if (w_push && !w_pop)      w_state_d = ST_FULL;
          else if (w_pop && !w_push) w_state_d = ST_EMPTY;
        end
        ST_FULL: if (w_pop) w_state_d = ST_BUSY;
        default: w_state_d = ST_EMPTY;
      endcase
    end
  end

  // valid/ready are registered from the next state so neither path is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_d;
      r_valid <= (w_state_d != ST_EMPTY);
      r_ready <= (w_state_d != ST_FULL);
      case (r_state)
        ST_EMPTY: if (w_push) r_main <= i_data;
        ST_BUSY: begin
          if (w_push && w_pop) r_main <= i_data;
          else if (w_push)     r_skid <= i_data;
        end
        ST_FULL: if (w_pop) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_main;

endmodule

// File: rtl/skid_pipeline.sv
// Cascade of STAGES skid stages with a registered beat-occupancy counter.
// Optional SKID_PIPE_FLUSH_EN adds a flush input that empties every stage.
module skid_pipeline
  import skid_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef SKID_PIPE_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [cnt_width(STAGES)-1:0]  occupancy
);

  localparam int unsigned CntW = cnt_width(STAGES);

  logic [STAGES:0]       w_valid;
  logic [STAGES:0]       w_ready;
  logic [DATA_WIDTH-1:0] w_data [STAGES+1];
  logic                  w_acc;
  logic                  w_emit;
  logic                  w_clr;
  logic [CntW-1:0]       r_occ;

`ifdef SKID_PIPE_FLUSH_EN
  assign w_clr = flush;
`else
  assign w_clr = 1'b0;
`endif

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign w_ready[STAGES] = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    skid_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef SKID_PIPE_FLUSH_EN
      .i_flush (flush),
`endif
      .i_valid (w_valid[gi]),
      .o_ready (w_ready[gi]),
      .i_data  (w_data[gi]),
      .o_valid (w_valid[gi+1]),
      .i_ready (w_ready[gi+1]),
      .o_data  (w_data[gi+1])
    );
  end

  // Flush masks the handshakes in the same cycle it is asserted.
  assign in_ready  = w_ready[0] & ~w_clr;
  assign out_valid = w_valid[STAGES] & ~w_clr;
  assign out_data  = w_data[STAGES];

  assign w_acc  = in_valid & in_ready;
  assign w_emit = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (w_clr) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + CntW'(w_acc) - CntW'(w_emit);
    end
  end

  assign occupancy = r_occ;

endmodule
